// File: rtl/fetch_decode_buffer_pkg.sv
// Shared fetch/decode constants: instruction width, the NOP filler word and the HALT encoding.
// Fetch, this buffer and decode all import these so the encodings stay in one place.
package fetch_decode_buffer_pkg;

  localparam int INSTR_W = 16;

  localparam logic [INSTR_W-1:0] NOP_INSTR  = 16'h0800;
  localparam logic [INSTR_W-1:0] HALT_INSTR = 16'h0000;

  function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
    return instr == HALT_INSTR;
  endfunction

endpackage

// File: rtl/fetch_decode_buffer_buf_entry.sv
// One buffer slot: a W-bit register holding {instr, pc_next}, loaded when we is high.
module fetch_decode_buffer_buf_entry #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: storage does not need clearing, because id_valid masks it; the reset only gives lint and gate-level sim a known value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_decode_buffer.sv
// Small FIFO between fetch and decode, with a valid/ready decode handshake, a flush for redirects,
// and a HALT lockout that blocks fetch until the next flush.
module fetch_decode_buffer #(
  parameter int                DEPTH      = 2,
  parameter int                WIDTH      = fetch_decode_buffer_pkg::INSTR_W,
  parameter logic [WIDTH-1:0]  NOP_INSTR  = fetch_decode_buffer_pkg::NOP_INSTR,
  parameter logic [WIDTH-1:0]  HALT_INSTR = fetch_decode_buffer_pkg::HALT_INSTR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [WIDTH-1:0] if_instr,
  input  logic [WIDTH-1:0] if_pc_next,
  output logic             if_ready,
  output logic             id_valid,
  output logic [WIDTH-1:0] id_instr,
  output logic [WIDTH-1:0] id_pc_next,
  input  logic             id_ready,
  input  logic             flush,
  output logic             halt_pending
);

  localparam int                PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]    FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W:0]       count;
  logic                 push;
  logic                 pop;
  logic [2*WIDTH-1:0]   entry_q [DEPTH];
  logic [2*WIDTH-1:0]   head;

  // Handshake signals depend only on registered state, so decode stalls never reach fetch combinationally.
  assign if_ready = (count < FULL_CNT) && !halt_pending;
  assign id_valid = (count != '0);
  assign push     = if_valid && if_ready && !flush;
  assign pop      = id_valid && id_ready && !flush;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    fetch_decode_buffer_buf_entry #(.W(2 * WIDTH)) u_entry (
      .clk (clk),
      .rst (rst),
      .we  (push && (wr_ptr == PTR_W'(i))),
      .d   ({if_instr, if_pc_next}),
      .q   (entry_q[i])
    );
  end

  assign head = entry_q[rd_ptr];

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    id_instr   = NOP_INSTR;
    id_pc_next = '0;
    if (id_valid) begin
      id_instr   = head[2*WIDTH-1:WIDTH];
      id_pc_next = head[WIDTH-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      halt_pending <= 1'b0;
    end else if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      halt_pending <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (if_instr == HALT_INSTR) begin
          halt_pending <= 1'b1;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/fetch_decode_buffer.md
Name: fetch_decode_buffer

Overview:
- Sits between the fetch stage and decode. It captures each fetched instruction and its incremented PC (PC+2) into a small FIFO.
- Presents entries to decode under a valid/ready handshake, which decouples decode stalls from fetch.
- Supports a flush for taken branches and jumps.
- Detects HALT and blocks further fetch until flushed or reset.

Parameters:
- DEPTH, 2, number of buffer entries (power of two, at least 2)
- WIDTH, 16, instruction and PC width in bits
- NOP_INSTR, 16'h0800, instruction word driven to decode when no valid entry is present
- HALT_INSTR, 16'h0000, instruction encoding treated as HALT

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_valid  in  1  fetch presents a valid instruction this cycle
- if_instr  in  WIDTH  fetched instruction word
- if_pc_next  in  WIDTH  PC+2 of the fetched instruction
- if_ready  out  1  buffer accepts a push this cycle; the fetch PC register write-enable is gated by this
- id_valid  out  1  head entry is valid for decode
- id_instr  out  WIDTH  head instruction, or NOP_INSTR when id_valid=0
- id_pc_next  out  WIDTH  head PC+2, or 0 when id_valid=0
- id_ready  in  1  decode consumes the head this cycle
- flush  in  1  discard all entries (redirect)
- halt_pending  out  1  a HALT has been accepted and not yet flushed

Behaviour:
- Reset (rst=0, asynchronous):
  - count=0, wr_ptr=0, rd_ptr=0, halt_pending=0.
  - Outputs: id_valid=0, id_instr=NOP_INSTR, id_pc_next=0, if_ready=1.
  - Entry storage is not required to clear.
- Push:
  - Occurs when if_valid & if_ready & ~flush.
  - Writes {if_instr, if_pc_next} at wr_ptr.
  - wr_ptr increments modulo DEPTH.
- Pop:
  - Occurs when id_valid & id_ready & ~flush.
  - rd_ptr increments modulo DEPTH.
- if_ready = (count < DEPTH) & ~halt_pending.
  - Derived from registered state only; there is no combinational path from id_ready to if_ready.
  - When full, a push is refused even in a cycle where a pop occurs.
- id_valid = (count != 0).
  - id_instr and id_pc_next come from the entry at rd_ptr, read from registers.
  - Push-to-visible latency is 1 cycle: data pushed at edge N is visible after edge N.
- Count update:
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop together: count unchanged. This is only possible when 0 < count < DEPTH.
  - When empty, a push with a same-cycle id_ready does not bypass; the pop happens the next cycle.
- Flush:
  - Highest priority.
  - Next cycle: count=0, rd_ptr=wr_ptr=0, halt_pending=0.
  - Any same-cycle push or pop is ignored.
- HALT:
  - A push whose if_instr == HALT_INSTR sets halt_pending=1 on that edge, so if_ready=0 from the next cycle.
  - The HALT entry still drains to decode normally.
  - halt_pending clears only on flush or reset.
- Pointers are log2(DEPTH) bits and wrap with no special case. count is log2(DEPTH)+1 bits.
- Illegal cases (neither may corrupt state):
  - if_valid while if_ready=0 is ignored.
  - id_ready while id_valid=0 is ignored.
- Reset asserted mid-operation takes immediate effect on all outputs, with no clock required.

Decomposition:
- Shared package holds NOP_INSTR, HALT_INSTR, and the instruction width constant. Fetch and decode also use these.
- One natural sub-module: buf_entry. This is a WIDTH*2-bit register with write-enable and asynchronous active-low reset, instantiated DEPTH times.
- Pointer, count, and halt control live in the top module.

Test Plan:
- Reset then idle (no if_valid):
  - id_valid=0, id_instr=16'h0800, if_ready=1, halt_pending=0 for 10 cycles.
- Back-to-back push with id_ready=1 (instr 16'h4001/pc 16'h0002, then 16'h4002/16'h0004, 16'h4003/16'h0006):
  - Decode sees each instruction exactly one cycle after its push, in order.
  - count never exceeds 1.
- Fill with id_ready=0 (push A=16'h1111, B=16'h2222):
  - After 2 pushes, if_ready=0 and a third push of 16'h3333 is dropped.
  - Raise id_ready: A, then B, then id_valid=0.
  - Exercises wrap of rd_ptr and wr_ptr to 0.
- Flush with count=2 plus a simultaneous push of 16'h5555:
  - Next cycle: id_valid=0, if_ready=1.
  - 16'h5555 is never presented to decode.
- HALT: push 16'h6000, then 16'h0000, with id_ready=1:
  - halt_pending=1 and if_ready=0 after the HALT edge.
  - Decode receives 16'h6000, then 16'h0000.
  - The buffer stays blocked until flush pulses, after which if_ready=1.
- Asynchronous reset asserted between clock edges with count=2:
  - id_valid=0 and id_instr=16'h0800 immediately, before the next edge.
  - After release, the first push appears in order.
